clk_rst_seq: RTL and testbench

- Parametrised multi-channel clock-enable and reset sequencer. Next generation of the single clk/rst_n bundle.
- From one clock and one synchronous active-high reset it produces:
  - NumChannels staggered active-low channel resets, released one at a time after a hold period.
  - A per-channel programmable clock-enable divider.
- Sits at the top of testbenches and subsystem wrappers. It drives the rst_n and enable of each downstream clk_if-style channel.

---
 rtl/clk_rst_seq.sv | 198 +++++++++++++++++++
 tb/tb_clk_rst_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/clk_rst_seq.sv
// clk_rst_seq: multi-channel staggered reset and clock-enable sequencer.
// Latency: all outputs registered; one clk from any input to its output effect.
// Backpressure: none; free-running sequencer with no handshake inputs.
//
// Ports:
//   clk          rising-edge clock for all logic
//   rst          synchronous active-high reset
//   soft_rst_i   single-cycle request to re-run the reset sequence
//   div_i        per-channel divisors, channel i at [i*CntWidth +: CntWidth]
//   div_load_i   samples div_i into the divisor registers
//   rst_n_o      per-channel active-low resets, released one by one
//   clk_en_o     per-channel clock-enable pulses (RUN only)
//   seq_done_o   high while in RUN
//   cycle_cnt_o  saturating RUN-cycle counter when CLK_RST_SEQ_CYCLE_CNT_EN
//                is defined, otherwise tied to zero
module clk_rst_seq #(
    parameter int NumChannels   = 4,
    parameter int CntWidth      = 8,
    parameter int RstHoldCycles = 16,
    parameter int StaggerCycles = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            soft_rst_i,
    input  logic [NumChannels*CntWidth-1:0] div_i,
    input  logic                            div_load_i,
    output logic [NumChannels-1:0]          rst_n_o,
    output logic [NumChannels-1:0]          clk_en_o,
    output logic                            seq_done_o,
    output logic [31:0]                     cycle_cnt_o
);

    localparam int HoldW = (RstHoldCycles > 1) ? $clog2(RstHoldCycles) : 1;
    localparam int StagW = (StaggerCycles > 1) ? $clog2(StaggerCycles) : 1;
    localparam int IdxW  = (NumChannels > 1) ? $clog2(NumChannels) : 1;

    localparam logic [HoldW-1:0] HoldLast   = HoldW'(RstHoldCycles - 1);
    localparam logic [StagW-1:0] StagReload = StagW'(StaggerCycles - 1);
    localparam logic [IdxW-1:0]  IdxLast    = IdxW'(NumChannels - 1);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2
    } state_e;

    state_e                          state_q, state_d;
    logic [HoldW-1:0]                hold_q, hold_d;
    logic [StagW-1:0]                stag_q, stag_d;
    logic [IdxW-1:0]                 idx_q, idx_d;
    logic [NumChannels-1:0]          rst_n_q, rst_n_d;
    logic [NumChannels-1:0]          en_q, en_d;
    logic                            done_q, done_d;
    logic [NumChannels*CntWidth-1:0] div_q, div_d;
    // Per-channel divider phase: the phase the next output cycle will have.
    // Phase 0 means that cycle carries a pulse.
    logic [NumChannels*CntWidth-1:0] dcnt_q, dcnt_d;
    logic                            run_next;

    always_comb begin
        logic [CntWidth-1:0] base_cnt;
        logic [CntWidth-1:0] d_cur;

        state_d  = state_q;
        hold_d   = hold_q;
        stag_d   = stag_q;
        idx_d    = idx_q;
        rst_n_d  = rst_n_q;
        done_d   = done_q;
        div_d    = div_q;
        dcnt_d   = '0;
        en_d     = '0;
        base_cnt = '0;
        d_cur    = '0;

        if (soft_rst_i) begin
            state_d = S_HOLD;
            hold_d  = '0;
            stag_d  = '0;
            idx_d   = '0;
            rst_n_d = '0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (hold_q == HoldLast) begin
                        state_d = S_RELEASE;
                        idx_d   = '0;
                        stag_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                S_RELEASE: begin
                    // stag_q==0 marks the edge on which the current channel
                    // is released; afterwards it counts down the spacing.
                    if (stag_q == '0) begin
                        rst_n_d[idx_q] = 1'b1;
                        if (idx_q == IdxLast) begin
                            state_d = S_RUN;
                            done_d  = 1'b1;
                        end else begin
                            idx_d  = idx_q + 1'b1;
                            stag_d = StagReload;
                        end
                    end else begin
                        stag_d = stag_q - 1'b1;
                    end
                end
                S_RUN: begin
                    state_d = S_RUN;
                end
                default: begin
                    state_d = S_HOLD;
                    hold_d  = '0;
                    rst_n_d = '0;
                    done_d  = 1'b0;
                end
            endcase
        end

        if (div_load_i) begin
            div_d = div_i;
        end

        // Dividers run in any cycle that will be spent in RUN, so the
        // first RUN cycle already carries a pulse for every d>=1.
        run_next = !soft_rst_i && (state_d == S_RUN);

        for (int i = 0; i < NumChannels; i++) begin
            // A load restarts every divider at phase 0 immediately.
            base_cnt = div_load_i ? '0 : dcnt_q[i*CntWidth +: CntWidth];
            d_cur    = div_d[i*CntWidth +: CntWidth];
            if (run_next && rst_n_d[i] && (d_cur != '0)) begin
                en_d[i] = (base_cnt == '0);
                if (base_cnt >= d_cur - CntWidth'(1)) begin
                    dcnt_d[i*CntWidth +: CntWidth] = '0;
                end else begin
                    dcnt_d[i*CntWidth +: CntWidth] = base_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_HOLD;
            hold_q  <= '0;
            stag_q  <= '0;
            idx_q   <= '0;
            rst_n_q <= '0;
            en_q    <= '0;
            done_q  <= 1'b0;
            div_q   <= {NumChannels{CntWidth'(1)}};
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            stag_q  <= stag_d;
            idx_q   <= idx_d;
            rst_n_q <= rst_n_d;
            en_q    <= en_d;
            done_q  <= done_d;
            div_q   <= div_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign rst_n_o    = rst_n_q;
    assign clk_en_o   = en_q;
    assign seq_done_o = done_q;

`ifdef CLK_RST_SEQ_CYCLE_CNT_EN
    logic [31:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (soft_rst_i) begin
            cyc_d = '0;
        end else if ((state_q == S_RUN) && (cyc_q != 32'hFFFF_FFFF)) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign cycle_cnt_o = cyc_q;
`else
    assign cycle_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_clk_rst_seq.sv
// tb_clk_rst_seq: directed self-checking bench for clk_rst_seq (default parameters).
// Latency: samples outputs 1 time unit after each rising edge.
// Backpressure: not applicable; every run ends on a bounded cycle count.
module tb_clk_rst_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        soft_rst_i;
    logic [31:0] div_i;
    logic        div_load_i;
    logic [3:0]  rst_n_o;
    logic [3:0]  clk_en_o;
    logic        seq_done_o;
    logic [31:0] cycle_cnt_o;

    int total = 0;
    int bad   = 0;
    int cur_div [4];

`ifdef CLK_RST_SEQ_CYCLE_CNT_EN
    localparam logic [31:0] ExpCnt100 = 32'd100;
`else
    localparam logic [31:0] ExpCnt100 = 32'd0;
`endif

    clk_rst_seq dut (
        .clk         (clk),
        .rst         (rst),
        .soft_rst_i  (soft_rst_i),
        .div_i       (div_i),
        .div_load_i  (div_load_i),
        .rst_n_o     (rst_n_o),
        .clk_en_o    (clk_en_o),
        .seq_done_o  (seq_done_o),
        .cycle_cnt_o (cycle_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rstn"}, {28'd0, rst_n_o}, 32'd0);
        chk({tag, "_en"},   {28'd0, clk_en_o}, 32'd0);
        chk({tag, "_done"}, {31'd0, seq_done_o}, 32'd0);
        chk({tag, "_cnt"},  cycle_cnt_o, 32'd0);
    endtask

    // Starts in the first HOLD cycle; ends in the first RUN cycle.
    task automatic run_seq(input logic [3:0] final_en);
        logic [3:0] rel [7];
        rel = '{4'h1, 4'h1, 4'h3, 4'h3, 4'h7, 4'h7, 4'hF};
        chk("hold_entry_rstn", {28'd0, rst_n_o}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            step();
            chk("hold_rstn", {28'd0, rst_n_o}, 32'd0);
            chk("hold_en",   {28'd0, clk_en_o}, 32'd0);
            chk("hold_done", {31'd0, seq_done_o}, 32'd0);
            chk("hold_cnt",  cycle_cnt_o, 32'd0);
        end
        for (int i = 0; i < 7; i++) begin
            step();
            chk("rel_rstn", {28'd0, rst_n_o}, {28'd0, rel[i]});
            if (i < 6) begin
                chk("rel_en",   {28'd0, clk_en_o}, 32'd0);
                chk("rel_done", {31'd0, seq_done_o}, 32'd0);
            end else begin
                chk("run0_en",   {28'd0, clk_en_o}, {28'd0, final_en});
                chk("run0_done", {31'd0, seq_done_o}, 32'd1);
            end
        end
    endtask

    // Current window is pulse offset 0 for all channels.
    task automatic chk_pattern(input int n);
        logic [3:0] e;
        for (int off = 0; off < n; off++) begin
            if (off > 0) step();
            for (int ch = 0; ch < 4; ch++) begin
                e[ch] = (cur_div[ch] == 0) ? 1'b0 : ((off % cur_div[ch]) == 0);
            end
            chk("div_pattern", {28'd0, clk_en_o}, {28'd0, e});
            chk("run_done", {31'd0, seq_done_o}, 32'd1);
        end
    endtask

    initial begin
        rst        = 1'b1;
        soft_rst_i = 1'b0;
        div_i      = '0;
        div_load_i = 1'b0;
        cur_div    = '{1, 1, 1, 1};

        // Power-on reset then the default sequence
        step(); step(); step();
        chk_reset_vals("por");
        rst = 1'b0;
        run_seq(4'hF);
        chk_pattern(3);

        // Load mixed divisors in RUN: ch3=0, ch2=1, ch1=3, ch0=4
        div_i      = {8'd0, 8'd1, 8'd3, 8'd4};
        div_load_i = 1'b1;
        step();
        div_load_i = 1'b0;
        cur_div    = '{4, 3, 1, 0};
        chk_pattern(11);

        // Soft reset at RUN cycle 10, divisors retained
        soft_rst_i = 1'b1;
        step();
        soft_rst_i = 1'b0;
        chk_reset_vals("soft");
        run_seq(4'b0111);
        chk_pattern(9);

        // Hard reset in the middle of RELEASE
        soft_rst_i = 1'b1;
        step();
        soft_rst_i = 1'b0;
        for (int i = 0; i < 19; i++) step();
        chk("mid_rel_rstn", {28'd0, rst_n_o}, 32'h3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_vals("midrel_rst");
        cur_div = '{1, 1, 1, 1};
        run_seq(4'hF);
        chk_pattern(3);

        // Simultaneous soft reset and divisor load
        div_i      = {4{8'd2}};
        soft_rst_i = 1'b1;
        div_load_i = 1'b1;
        step();
        soft_rst_i = 1'b0;
        div_load_i = 1'b0;
        chk_reset_vals("soft_load");
        cur_div = '{2, 2, 2, 2};
        run_seq(4'hF);
        chk_pattern(6);

        // RUN cycle counter
        soft_rst_i = 1'b1;
        step();
        soft_rst_i = 1'b0;
        chk("cnt_after_soft", cycle_cnt_o, 32'd0);
        run_seq(4'hF);
        chk("cnt_run0", cycle_cnt_o, 32'd0);
        for (int i = 0; i < 100; i++) step();
        chk("cnt_run100", cycle_cnt_o, ExpCnt100);
        soft_rst_i = 1'b1;
        step();
        soft_rst_i = 1'b0;
        chk("cnt_cleared", cycle_cnt_o, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("cnt_hold", cycle_cnt_o, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
